// File: rtl/cpu_pkg.sv
// Shared definitions for the decode, ALU and writeback stages.
// Covers the opcode map, condition codes, shifter controls and instruction field layout.
package cpu_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_MUL  = 4'b0010;
   localparam logic [3:0] OP_ORR  = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_EOR  = 4'b0101;
   localparam logic [3:0] OP_MOVI = 4'b0110;
   localparam logic [3:0] OP_MOV  = 4'b0111;
   localparam logic [3:0] OP_CMP  = 4'b1011;
   localparam logic [3:0] OP_LDR  = 4'b1101;
   localparam logic [3:0] OP_STR  = 4'b1110;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;

   localparam logic [2:0] SR_NONE = 3'd0;
   localparam logic [2:0] SR_LSL  = 3'd1;
   localparam logic [2:0] SR_LSR  = 3'd2;
   localparam logic [2:0] SR_ASR  = 3'd3;
   localparam logic [2:0] SR_ROR  = 3'd4;

   localparam int COND_MSB = 31, COND_LSB = 28;
   localparam int OP_MSB   = 27, OP_LSB   = 24;
   localparam int S_BIT    = 23;
   localparam int RD_MSB   = 22, RD_LSB   = 19;
   localparam int RN_MSB   = 18, RN_LSB   = 15;
   localparam int RM_MSB   = 14, RM_LSB   = 11;
   localparam int SRC_MSB  = 10, SRC_LSB  = 8;
   localparam int SRB_MSB  = 7,  SRB_LSB  = 3;
   localparam int IMM_MSB  = 15, IMM_LSB  = 0;

   typedef struct packed {
      logic [3:0]  cond;
      logic [3:0]  opcode;
      logic        s;
      logic [3:0]  rd;
      logic [3:0]  rn;
      logic [3:0]  rm;
      logic [2:0]  sr_cont;
      logic [4:0]  sr_bit;
      logic [15:0] imm;
   } fields_t;

   typedef struct packed {
      logic [31:0] alu_in1;
      logic [31:0] alu_in2;
      logic [3:0]  opcode;
      logic [3:0]  cond;
      logic        s;
      logic [2:0]  sr_cont;
      logic [4:0]  sr_bit;
      logic [15:0] imm;
      logic [3:0]  rd;
      logic        rd_we;
   } dec_t;

   function automatic fields_t split(input logic [31:0] i);
      fields_t f;
      f.cond    = i[COND_MSB:COND_LSB];
      f.opcode  = i[OP_MSB:OP_LSB];
      f.s       = i[S_BIT];
      f.rd      = i[RD_MSB:RD_LSB];
      f.rn      = i[RN_MSB:RN_LSB];
      f.rm      = i[RM_MSB:RM_LSB];
      f.sr_cont = i[SRC_MSB:SRC_LSB];
      f.sr_bit  = i[SRB_MSB:SRB_LSB];
      f.imm     = i[IMM_MSB:IMM_LSB];
      return f;
   endfunction

   function automatic logic writes_rd(input logic [3:0] op);
      return (op <= OP_MOV) || (op == OP_LDR);
   endfunction

   function automatic logic uses_rn(input logic [3:0] op);
      return op != OP_MOVI;
   endfunction

   function automatic logic uses_rm(input logic [3:0] op);
      return (op <= OP_EOR) || (op == OP_CMP);
   endfunction

endpackage

// File: rtl/reg_file.sv
// 16 x 32 register file, two combinational reads and one write.
// A same-cycle write is forwarded to either read port.
module reg_file
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we,
   input  logic [3:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [3:0]  raddr1,
   input  logic [3:0]  raddr2,
   output logic [31:0] rdata1,
   output logic [31:0] rdata2
);

   logic [15:0][31:0] mem;

   always_ff @(posedge clk) begin
      if (!rst_n)  mem <= '0;
      else if (we) mem[waddr] <= wdata;
   end

   assign rdata1 = (we && waddr == raddr1) ? wdata : mem[raddr1];
   assign rdata2 = (we && waddr == raddr2) ? wdata : mem[raddr2];

endmodule

// File: rtl/instr_decode.sv
// Decode stage: operand fetch, scoreboard hazard check and a single output
// register with valid/ready handshakes on both sides.
module instr_decode
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic        wb_en,
   input  logic [3:0]  wb_addr,
   input  logic [31:0] wb_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] alu_in1,
   output logic [31:0] alu_in2,
   output logic [3:0]  opcode,
   output logic [3:0]  cond,
   output logic        s,
   output logic [2:0]  sr_cont,
   output logic [4:0]  sr_bit,
   output logic [15:0] imm,
   output logic [3:0]  rd,
   output logic        rd_we
);

   fields_t     f;
   dec_t        dec_d, dec_q;
   logic [31:0] rdata1, rdata2;
   logic [15:0] pending, set_mask, clr_mask;
   logic        use_rn, use_rm, we_new, hazard, accept;

   assign f = split(instr);

   reg_file u_rf (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (wb_en),
      .waddr  (wb_addr),
      .wdata  (wb_data),
      .raddr1 (f.rn),
      .raddr2 (f.rm),
      .rdata1 (rdata1),
      .rdata2 (rdata2)
   );

   assign use_rn = uses_rn(f.opcode);
   assign use_rm = uses_rm(f.opcode);
   assign we_new = writes_rd(f.opcode);

   // A pending register being written back this cycle is covered by the bypass.
   assign hazard = (use_rn && pending[f.rn] && !(wb_en && wb_addr == f.rn)) ||
                   (use_rm && pending[f.rm] && !(wb_en && wb_addr == f.rm));

   assign instr_ready = rst_n && !hazard && (!out_valid || out_ready);
   assign accept      = instr_valid && instr_ready;

   always_comb begin
      dec_d         = '0;
      dec_d.alu_in1 = use_rn ? rdata1 : 32'd0;
      dec_d.alu_in2 = use_rm ? rdata2 : 32'd0;
      dec_d.opcode  = f.opcode;
      dec_d.cond    = f.cond;
      dec_d.s       = f.s;
      dec_d.sr_cont = f.sr_cont;
      dec_d.sr_bit  = f.sr_bit;
      dec_d.imm     = (f.opcode == OP_MOVI) ? f.imm : 16'd0;
      dec_d.rd      = f.rd;
      dec_d.rd_we   = we_new;
   end

   assign set_mask = (accept && we_new) ? (16'd1 << f.rd)   : 16'd0;
   assign clr_mask = wb_en              ? (16'd1 << wb_addr) : 16'd0;

   always_ff @(posedge clk) begin
      if (!rst_n) pending <= '0;
      else        pending <= (pending & ~clr_mask) | set_mask;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         dec_q     <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         dec_q     <= dec_d;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign alu_in1 = dec_q.alu_in1;
   assign alu_in2 = dec_q.alu_in2;
   assign opcode  = dec_q.opcode;
   assign cond    = dec_q.cond;
   assign s       = dec_q.s;
   assign sr_cont = dec_q.sr_cont;
   assign sr_bit  = dec_q.sr_bit;
   assign imm     = dec_q.imm;
   assign rd      = dec_q.rd;
   assign rd_we   = dec_q.rd_we;

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode: reset, bypass, hazard stall, output hold,
// streaming and reset during a stall.
module tb_instr_decode;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, instr_valid, instr_ready, wb_en, out_valid, out_ready;
   logic [31:0] instr, wb_data, alu_in1, alu_in2;
   logic [3:0]  wb_addr, opcode, cond, rd;
   logic        s, rd_we;
   logic [2:0]  sr_cont;
   logic [4:0]  sr_bit;
   logic [15:0] imm;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   instr_decode dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .opcode(opcode), .cond(cond), .s(s), .sr_cont(sr_cont), .sr_bit(sr_bit),
      .imm(imm), .rd(rd), .rd_we(rd_we)
   );

   function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] d,
                                       input logic [3:0] n, input logic [3:0] m);
      return {COND_AL, op, 1'b0, d, n, m, 11'd0};
   endfunction

   function automatic logic [31:0] movi(input logic [3:0] d, input logic [15:0] v);
      return {COND_AL, OP_MOVI, 1'b0, d, 3'd0, v};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wb(input logic [3:0] a, input logic [31:0] d);
      wb_en = 1'b1; wb_addr = a; wb_data = d;
      tick();
      wb_en = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; instr_valid = 1'b0; instr = '0; out_ready = 1'b1;
      wb_en = 1'b1; wb_addr = 4'd1; wb_data = 32'hDEAD_BEEF;
      tick();
      #1 check("ready_in_reset", {31'd0, instr_ready}, 32'd0);
      tick();
      wb_en = 1'b0; rst_n = 1'b1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_alu_in1", alu_in1, 32'd0);
      check("rst_opcode", {28'd0, opcode}, 32'd0);
      check("rst_pending", {16'd0, dut.pending}, 32'd0);
      check("rst_wb_ignored", dut.u_rf.mem[1], 32'd0);

      // Writebacks with nothing pending still land in the register file
      wb(4'd1, 32'd5);
      wb(4'd2, 32'd7);

      instr = enc(OP_ADD, 4'd3, 4'd1, 4'd2); instr_valid = 1'b1;
      #1 check("add_ready", {31'd0, instr_ready}, 32'd1);
      tick();
      instr_valid = 1'b0;
      check("add_valid", {31'd0, out_valid}, 32'd1);
      check("add_in1", alu_in1, 32'd5);
      check("add_in2", alu_in2, 32'd7);
      check("add_opcode", {28'd0, opcode}, 32'd0);
      check("add_cond", {28'd0, cond}, 32'hE);
      check("add_rd", {28'd0, rd}, 32'd3);
      check("add_rd_we", {31'd0, rd_we}, 32'd1);
      check("add_pending", {16'd0, dut.pending}, 32'h0008);
      wb(4'd3, 32'd12);
      check("add_drained", {31'd0, out_valid}, 32'd0);
      check("pending_clr", {16'd0, dut.pending}, 32'h0000);

      // MOVI then a dependent ADD: stall until the bypassed writeback
      instr = movi(4'd4, 16'h1234); instr_valid = 1'b1;
      tick();
      check("movi_imm", {16'd0, imm}, 32'h1234);
      check("movi_in1", alu_in1, 32'd0);
      check("movi_op", {28'd0, opcode}, {28'd0, OP_MOVI});
      instr = enc(OP_ADD, 4'd5, 4'd4, 4'd4);
      #1 check("raw_stall0", {31'd0, instr_ready}, 32'd0);
      tick();
      check("raw_stall1", {31'd0, instr_ready}, 32'd0);
      check("raw_bubble", {31'd0, out_valid}, 32'd0);
      wb_en = 1'b1; wb_addr = 4'd4; wb_data = 32'h1234;
      #1 check("raw_release", {31'd0, instr_ready}, 32'd1);
      tick();
      wb_en = 1'b0; instr_valid = 1'b0;
      check("raw_valid", {31'd0, out_valid}, 32'd1);
      check("raw_in1", alu_in1, 32'h1234);
      check("raw_in2", alu_in2, 32'h1234);
      check("raw_rd", {28'd0, rd}, 32'd5);
      check("raw_pending", {16'd0, dut.pending}, 32'h0020);
      wb(4'd5, 32'h2468);

      // Output hold under backpressure
      out_ready = 1'b0;
      instr = enc(OP_ADD, 4'd6, 4'd1, 4'd2); instr_valid = 1'b1;
      tick();
      instr = enc(OP_SUB, 4'd7, 4'd1, 4'd2);
      for (int i = 0; i < 3; i++) begin
         check("hold_ready", {31'd0, instr_ready}, 32'd0);
         check("hold_valid", {31'd0, out_valid}, 32'd1);
         check("hold_in1", alu_in1, 32'd5);
         check("hold_rd", {28'd0, rd}, 32'd6);
         check("hold_op", {28'd0, opcode}, 32'd0);
         tick();
      end
      out_ready = 1'b1;
      #1 check("unhold_ready", {31'd0, instr_ready}, 32'd1);
      tick();
      instr_valid = 1'b0;
      check("sub_op", {28'd0, opcode}, {28'd0, OP_SUB});
      check("sub_rd", {28'd0, rd}, 32'd7);
      check("sub_valid", {31'd0, out_valid}, 32'd1);
      wb(4'd6, 32'd12);
      wb(4'd7, 32'hFFFF_FFFE);
      check("hold_drained", {31'd0, out_valid}, 32'd0);

      // Non-writing and undefined opcodes leave the scoreboard alone
      instr = enc(OP_CMP, 4'd9, 4'd1, 4'd2); instr_valid = 1'b1;
      tick();
      check("cmp_rd_we", {31'd0, rd_we}, 32'd0);
      check("cmp_in2", alu_in2, 32'd7);
      instr = enc(OP_STR, 4'd9, 4'd1, 4'd2);
      tick();
      check("str_rd_we", {31'd0, rd_we}, 32'd0);
      check("str_in1", alu_in1, 32'd5);
      check("str_in2", alu_in2, 32'd0);
      instr = enc(4'b1000, 4'd9, 4'd1, 4'd2);
      tick();
      instr_valid = 1'b0;
      check("undef_op", {28'd0, opcode}, 32'h8);
      check("undef_rd_we", {31'd0, rd_we}, 32'd0);
      check("undef_in2", alu_in2, 32'd0);
      tick();
      check("nowrite_pending", {16'd0, dut.pending}, 32'h0000);

      // Four independent ADDs streamed at one per cycle
      for (int i = 0; i < 4; i++) begin
         instr = enc(OP_ADD, 4'(8 + i), 4'd1, 4'd2);
         if (i == 0) instr = instr | (32'(SR_LSR) << 8) | (32'd5 << 3);
         instr_valid = 1'b1;
         #1 check("stream_ready", {31'd0, instr_ready}, 32'd1);
         tick();
         check("stream_valid", {31'd0, out_valid}, 32'd1);
         check("stream_rd", {28'd0, rd}, 32'(8 + i));
         if (i == 0) begin
            check("stream_sr_cont", {29'd0, sr_cont}, {29'd0, SR_LSR});
            check("stream_sr_bit", {27'd0, sr_bit}, 32'd5);
         end
      end
      instr_valid = 1'b0;
      tick();
      check("stream_end", {31'd0, out_valid}, 32'd0);
      check("stream_pending", {16'd0, dut.pending}, 32'h0F00);
      for (int i = 8; i < 12; i++) wb(4'(i), 32'd12);

      // Reset during a stall discards the held instruction
      instr = movi(4'd4, 16'h0055); instr_valid = 1'b1;
      tick();
      instr = enc(OP_ADD, 4'd5, 4'd4, 4'd4);
      tick();
      check("stall2_ready", {31'd0, instr_ready}, 32'd0);
      check("stall2_pending", {16'd0, dut.pending}, 32'h0010);
      rst_n = 1'b0;
      tick();
      check("rst2_valid", {31'd0, out_valid}, 32'd0);
      check("rst2_pending", {16'd0, dut.pending}, 32'h0000);
      check("rst2_r4", dut.u_rf.mem[4], 32'd0);
      rst_n = 1'b1; instr_valid = 1'b0;
      tick();
      check("rst2_no_replay", {31'd0, out_valid}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 Parameters SHALL be none; all widths are fixed by the 32-bit instruction format.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 instr  in  32  instruction word; fields Cond[31:28] Opcode[27:24] S[23] Rd[22:19] Rn[18:15] Rm[14:11] SR_Cont[10:8] SR_Bit[7:3]; Imm16[15:0], used only by MOVI.
REQ-005 instr_valid / instr_ready  in / out  1 / 1  upstream handshake; transfer when both are high.
REQ-006 wb_en, wb_addr, wb_data  in  1 / 4 / 32  writeback port into register file.
REQ-007 out_valid / out_ready  out / in  1 / 1  downstream handshake to the execute stage.
REQ-008 alu_in1, alu_in2  out  32 / 32  operands; In1 = R[Rn], In2 = R[Rm].
REQ-009 opcode, cond, s, sr_cont, sr_bit, imm  out  4 / 4 / 1 / 3 / 5 / 16  decoded control fields for the ALU.
REQ-010 rd, rd_we  out  4 / 1  destination register and its write-enable for writeback.

Function
REQ-011 Register file: 16 x 32 entries, 2 combinational reads (Rn, Rm), 1 write (wb_en at clock edge).
REQ-012 Read bypass: if wb_en and wb_addr equals a read address in the same cycle, that read returns wb_data.
REQ-013 Rd-writing opcodes: 0000-0111 and 1101. For 1011 (CMP), 1110 (STR) and undefined opcodes, rd_we = 0.
REQ-014 Operand use:
- Rn is used by all opcodes except 0110 (MOVI).
- Rm is used by 0000-0101 and 1011.
- Unused operand outputs are driven 0.
REQ-015 imm SHALL equal instr[15:0] for MOVI and 0 otherwise.
REQ-016 Scoreboard: 16 pending bits.
- A bit is set on accept of an instruction with rd_we = 1.
- A bit is cleared on wb_en for wb_addr.
- If set and clear hit the same register in the same cycle, set wins.
REQ-017 Hazard: pending[used Rn] or pending[used Rm] is high, unless that register is being written back this cycle (bypass covers it).
REQ-018 instr_ready = !hazard && (!out_valid || out_ready).
- While stalled, the instruction is held upstream.
- No bubble is inserted while out_valid = 1.
REQ-019 The output register loads on accept and sets out_valid.
- out_valid clears when out_ready is high and no new accept occurs in that cycle.
- Latency is 1 cycle from accept to out_valid.
REQ-020 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-021 Back-to-back accept with out_ready held high SHALL sustain 1 instruction per cycle.
REQ-022 Undefined opcodes (1000, 1001, 1010, 1100, 1111) SHALL be accepted and forwarded unchanged with rd_we = 0 and no scoreboard effect.
REQ-023 Writeback to a register with no pending bit set SHALL still update the register file and is not an error.

Reset
REQ-024 When rst_n is low at a clock edge:
- all 16 registers, all pending bits and out_valid clear to 0;
- all data/control outputs clear to 0;
- instr_ready is 0 during the reset cycle.
REQ-025 Reset mid-stall or mid-hold SHALL discard the held instruction; nothing is replayed after reset.
REQ-026 A wb_en asserted in the reset cycle SHALL be ignored.

Structure
REQ-027 Package cpu_pkg SHALL hold the following, shared with the ALU and writeback stages:
- opcode constants (ADD, SUB, MUL, ORR, AND, EOR, MOVI, MOV, CMP, LDR, STR);
- condition codes;
- SR_Cont encodings;
- instruction field bit positions.
REQ-028 Sub-module reg_file (2R1W, write bypass, synchronous reset) SHALL be instantiated once; scoreboard and handshake logic remain in instr_decode.

Verification
REQ-029 Reset, then writeback R1 = 5 and R2 = 7; issue ADD R3, R1, R2 -> 1 cycle later out_valid = 1, alu_in1 = 5, alu_in2 = 7, opcode = 0000, rd = 3, rd_we = 1.
REQ-030 Issue MOVI R4, 0x1234 then ADD R5, R4, R4 -> ADD stalls (instr_ready = 0) until wb_en with wb_addr = 4, wb_data = 0x1234; in that same cycle ADD is accepted with alu_in1 = alu_in2 = 0x1234.
REQ-031 Hold out_ready = 0 for 3 cycles with a valid output -> outputs unchanged and instr_ready = 0; raise out_ready -> next instruction accepted in the same cycle.
REQ-032 Issue CMP R1, R2 then STR R1 -> rd_we = 0 for both and pending stays 0x0000.
REQ-033 Stream 4 independent ADDs with out_ready = 1 -> out_valid high for 4 consecutive cycles in order.
REQ-034 Assert rst_n = 0 during a stall with pending[4] = 1 -> next cycle out_valid = 0, pending = 0, R4 = 0.
